muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative signed multiply/divide unit in the execute stage of the pipelined MIPS core. It consumes the E-stage control bits `hlwriteE` and `multordivE` produced by the controller's ID/EX register, plus the E-stage ALU operands. It computes MULT/DIV results over multiple cycles into private HI/LO registers. While an operation is in flight it raises `busy`; the hazard unit uses `busy` to stall subsequent HI/LO-dependent instructions.

## Interface
Parameters:
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. Asserting it low immediately clears all state.
- `hlwriteE` input 1: start request; the E-stage instruction writes HI/LO.
- `multordivE` input 1: operation select; 0 = MULT, 1 = DIV.
- `srcaE` input WIDTH: rs operand (multiplicand or dividend), two's complement.
- `srcbE` input WIDTH: rt operand (multiplier or divisor), two's complement.
- `hi` output WIDTH: HI register (product upper half, or remainder).
- `lo` output WIDTH: LO register (product lower half, or quotient).
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse in the first cycle new HI/LO values are visible.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - If `hlwriteE`=1 at a rising edge, capture |srcaE|, |srcbE|, both sign bits, and `multordivE`.
  - Clear the 6-bit iteration counter and go to RUN.
  - Otherwise stay in IDLE.
- RUN: perform one iteration per cycle. The counter increments 0..WIDTH-1. At count WIDTH-1, go to FIN.
  - MULT: radix-2 shift-add on magnitudes into a 2·WIDTH accumulator.
  - DIV: restoring division on magnitudes. Each step shifts the partial remainder left by 1 and brings in the next dividend bit. Subtract if the result is non-negative and shift the quotient bit in.
- FIN: apply the sign, load `hi`/`lo`, and go to IDLE.
  - MULT: negate the 64-bit product if the operand signs differ. `hi` = [2W-1:W], `lo` = [W-1:0].
  - DIV: negate the quotient if the signs differ. The remainder takes the sign of the dividend. `lo` = quotient, `hi` = remainder.
- Divide by zero: skip the sign fix. `lo` = all ones, `hi` = srcaE as captured (original signed value).
- Overflow case −2^(W−1) / −1: `lo` = 0x80000000, `hi` = 0. This falls out of the magnitude path and needs no special case.
- `hlwriteE` while `busy`=1 (RUN or FIN) is ignored; no error is flagged. The hazard unit must stall the pipeline so that this cannot occur.
- `hlwriteE` in the cycle after FIN (state IDLE) is accepted normally.
- `hi`/`lo` hold their values at all times except the FIN→IDLE edge.
- Reset low at any time, including mid-RUN:
  - State goes to IDLE, the operation is aborted, and the counter is cleared.
  - `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0.
  - No partial result is ever written.

## Timing
- Start is sampled at edge k. `busy` = 1 from cycle k+1 through k+33 (32 RUN cycles plus 1 FIN cycle).
- New `hi`/`lo` and `done` = 1 appear in cycle k+34, and `busy` = 0 in that same cycle. Total latency is WIDTH+2 cycles from the start edge to result visibility.
- `done` is registered and lasts exactly one cycle.
- `busy` is registered, not combinational from `hlwriteE`. The hazard unit covers the start cycle itself by decoding `hlwriteE` directly.
- Back-to-back operations: earliest second start at edge k+34, with results at k+68.
- All outputs are 0 while reset is low and for the first cycle after release.

## Test plan
- Reset: `reset` low, then high.
  - Expect `hi` = `lo` = 0 and `busy` = `done` = 0.
  - Hold `hlwriteE` = 0 for 50 cycles: no change.
- MULT 7 × −3 (srcaE = 0x00000007, srcbE = 0xFFFFFFFD):
  - `busy` high for 33 cycles.
  - Then `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB, with a single `done` pulse at k+34.
- DIV −7 / 2 (srcaE = 0xFFFFFFF9, srcbE = 0x00000002) → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Repeat with 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- DIV 5 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000005.
- Start MULT 0x00010000 × 0x00010000. Pulse `hlwriteE` with new operands at k+5 and again at FIN.
  - Those pulses are ignored.
  - Result `hi` = 0x00000001, `lo` = 0.
  - A start at k+34 is accepted.
- Start DIV 100 / 3 and drive `reset` low at cycle k+10 for 1 cycle.
  - `busy` drops immediately and `hi`/`lo` = 0, with no `done`.
  - A new DIV 100 / 3 then yields `lo` = 33, `hi` = 1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV unit for the E stage: 32 shift-add / restoring-divide
// iterations on operand magnitudes, then a sign-fix cycle that loads HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hlwriteE,
  input  logic             multordivE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

  state_t             state_r;
  logic [5:0]         cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   op_mag_r;
  logic [WIDTH-1:0]   src_a_r;
  logic               b_neg_r;
  logic               div_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic [2*WIDTH-1:0] acc_step_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;
  logic               sign_diff_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    neg_w = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
    abs_w = x[WIDTH-1] ? neg_w(x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    neg_2w = ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign hi   = hi_r;
  assign lo   = lo_r;
  assign busy = busy_r;
  assign done = done_r;

  assign sign_diff_s = src_a_r[WIDTH-1] ^ b_neg_r;

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, op_mag_r} : {(WIDTH+1){1'b0}});
    div_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_shift_s - {1'b0, op_mag_r};
    acc_step_s  = acc_r;
    if (div_r) begin
      if (!div_diff_s[WIDTH]) begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the magnitude result; divide by zero bypasses it
  always_comb begin
    prod_s   = acc_r;
    fin_hi_s = {WIDTH{1'b0}};
    fin_lo_s = {WIDTH{1'b0}};
    if (div_r) begin
      if (op_mag_r == {WIDTH{1'b0}}) begin
        fin_lo_s = {WIDTH{1'b1}};
        fin_hi_s = src_a_r;
      end else begin
        fin_lo_s = sign_diff_s ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
        fin_hi_s = src_a_r[WIDTH-1] ? neg_w(acc_r[2*WIDTH-1:WIDTH])
                                    : acc_r[2*WIDTH-1:WIDTH];
      end
    end else begin
      prod_s   = sign_diff_s ? neg_2w(acc_r) : acc_r;
      fin_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Control FSM with registered HI/LO, busy and done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= 6'd0;
      acc_r    <= {(2*WIDTH){1'b0}};
      op_mag_r <= {WIDTH{1'b0}};
      src_a_r  <= {WIDTH{1'b0}};
      b_neg_r  <= 1'b0;
      div_r    <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (hlwriteE) begin
            state_r  <= RUN;
            busy_r   <= 1'b1;
            cnt_r    <= 6'd0;
            div_r    <= multordivE;
            src_a_r  <= srcaE;
            b_neg_r  <= srcbE[WIDTH-1];
            op_mag_r <= multordivE ? abs_w(srcbE) : abs_w(srcaE);
            acc_r    <= {{WIDTH{1'b0}}, (multordivE ? abs_w(srcaE) : abs_w(srcbE))};
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LAST_CNT) begin
            state_r <= FIN;
          end else begin
            state_r <= RUN;
          end
        end
        FIN: begin
          hi_r    <= fin_hi_s;
          lo_r    <= fin_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: signed MULT/DIV vectors,
// latency, ignored starts while busy, and reset abort.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        hlwriteE;
  logic        multordivE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .hlwriteE   (hlwriteE),
    .multordivE (multordivE),
    .srcaE      (srcaE),
    .srcbE      (srcbE),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic h, input logic d, input logic [31:0] a, input logic [31:0] b);
    hlwriteE   = h;
    multordivE = d;
    srcaE      = a;
    srcbE      = b;
  endtask

  // Leaves the bench at the falling edge of cycle k+1 (k = sampling edge)
  task automatic start_op(input logic d, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, d, a, b);
    @(negedge clk);
    hlwriteE = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc = 0;
    logic early_done = 1'b0;
    while (busy === 1'b1 && cyc < 60) begin
      if (done !== 1'b0) early_done = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, cyc, 32'd33);
    chk({tag, " early done"}, {31'd0, early_done}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    @(negedge clk);
    chk({tag, " done width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    seen = 1'b0;
    repeat (50) begin
      if ((hi | lo) !== 32'd0 || busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    chk("idle quiet", {31'd0, seen}, 32'd0);

    start_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    chk("mul busy k+1", {31'd0, busy}, 32'd1);
    chk("mul hi held", hi, 32'd0);
    wait_result("mul 7x-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    start_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_result("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div ovf", 32'h0000_0000, 32'h8000_0000);

    start_op(1'b1, 32'h0000_0005, 32'h0000_0000);
    wait_result("div 5/0", 32'h0000_0005, 32'hFFFF_FFFF);

    start_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_result("div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD);

    start_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_result("mul min*min", 32'h4000_0000, 32'h0000_0000);

    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("mul -1*-1", 32'h0000_0000, 32'h0000_0001);

    // Starts during RUN (edge k+5) and FIN (edge k+33) must be dropped
    start_op(1'b0, 32'h0001_0000, 32'h0001_0000);
    repeat (4) @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0055, 32'h0000_0003);
    @(negedge clk);
    hlwriteE = 1'b0;
    repeat (27) @(negedge clk);
    chk("fin busy", {31'd0, busy}, 32'd1);
    chk("fin done", {31'd0, done}, 32'd0);
    drive(1'b1, 1'b0, 32'h0000_0003, 32'h0000_0004);
    @(negedge clk);
    chk("ign done", {31'd0, done}, 32'd1);
    chk("ign busy", {31'd0, busy}, 32'd0);
    chk("ign hi", hi, 32'h0000_0001);
    chk("ign lo", lo, 32'h0000_0000);
    @(negedge clk);
    hlwriteE = 1'b0;
    chk("b2b busy", {31'd0, busy}, 32'd1);
    wait_result("mul 3x4", 32'h0000_0000, 32'h0000_000C);

    // Reset abort in the middle of a divide
    start_op(1'b1, 32'd100, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0 || (hi | lo) !== 32'd0) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort no result", {31'd0, seen}, 32'd0);

    start_op(1'b1, 32'd100, 32'd3);
    wait_result("div 100/3", 32'd1, 32'd33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
